ag_6502: RTL and testbench

Reduced-instruction-set 6502-compatible CPU core: the processor block on the system bus, driving a 16-bit address bus and 8-bit split data buses. One bus cycle per CLK period. Runs the 6502 reset-vector sequence and a defined opcode subset, with NMI and IRQ. Every undefined opcode executes as a 2-cycle NOP.

---
 rtl/ag_6502.sv | 167 ++++++++++++++++
 tb/tb_ag_6502.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag_6502.sv
// rtl/ag_6502.sv - reduced 6502-compatible CPU core
// One bus cycle per CLK; AB/RDWR_/DO/SYNC describe the cycle currently on the bus.
module ag_6502 (
  input  logic        CLK,
  input  logic        RESET,
  output logic        CLK_01,
  output logic        CLK_02,
  output logic [15:0] AB,
  output logic        RDWR_,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        RDY,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        SO,
  output logic        SYNC
);

  typedef enum logic [4:0] {
    S_RESET, S_RS1, S_RS2, S_RS3, S_VECL, S_VECH, S_FETCH, S_OP,
    S_ABSH, S_ABSX, S_BR, S_RTI1, S_RTI2, S_RTI3, S_RTI4,
    S_INT0, S_INT1, S_INT2, S_INT3, S_INT4
  } state_t;

  state_t      state;
  logic [7:0]  a, x, y, sp, ir, tmp;
  logic [15:0] pc;
  logic        p_n, p_v, p_d, p_i, p_z, p_c;
  logic        nmi_q, nmi_pend, so_q, int_nmi;

  logic        stall, fin, set_nz, br_take, take_int, ovf;
  logic [15:0] fin_pc, br_target;
  logic [7:0]  res;
  logic [8:0]  sum;

  assign CLK_01    = ~CLK;
  assign CLK_02    = CLK;
  assign stall     = ~RDY & RDWR_;
  assign sum       = {1'b0, a} + {1'b0, DI} + {8'd0, p_c};
  assign ovf       = (a[7] == DI[7]) && (sum[7] != a[7]);
  assign br_take   = (ir == 8'hD0) ? ~p_z : p_z;
  assign br_target = pc + 16'd1 + {{8{DI[7]}}, DI};
  assign take_int  = nmi_pend | (IRQ & ~p_i);

  // fin marks the last cycle of an instruction; fin_pc is where the next one starts
  always_comb begin
    fin    = 1'b0;
    fin_pc = pc;
    res    = DI;
    set_nz = 1'b0;
    case (state)
      S_OP: begin
        fin = 1'b1;
        case (ir)
          8'hA9, 8'hA2, 8'hA0: begin set_nz = 1'b1; fin_pc = pc + 16'd1; end
          8'h69: begin res = sum[7:0]; set_nz = 1'b1; fin_pc = pc + 16'd1; end
          8'hE8: begin res = x + 8'd1; set_nz = 1'b1; end
          8'hCA: begin res = x - 8'd1; set_nz = 1'b1; end
          8'hC8: begin res = y + 8'd1; set_nz = 1'b1; end
          8'h88: begin res = y - 8'd1; set_nz = 1'b1; end
          8'hAA: begin res = a; set_nz = 1'b1; end
          8'h8A: begin res = x; set_nz = 1'b1; end
          8'hAD, 8'h8D, 8'h4C, 8'h40: fin = 1'b0;
          8'hD0, 8'hF0: begin fin = ~br_take; fin_pc = pc + 16'd1; end
          default: ;
        endcase
      end
      S_ABSH: begin fin = (ir == 8'h4C); fin_pc = {DI, tmp}; end
      S_ABSX: begin fin = 1'b1; set_nz = (ir == 8'hAD); end
      S_BR:   fin = 1'b1;
      S_RTI4, S_VECH: begin fin = 1'b1; fin_pc = {DI, tmp}; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_RESET;
      AB <= 16'h0000; RDWR_ <= 1'b1; DO <= 8'h00; SYNC <= 1'b0;
      a <= 8'h00; x <= 8'h00; y <= 8'h00; sp <= 8'h00;
      ir <= 8'hEA; tmp <= 8'h00; pc <= 16'h0000;
      p_n <= 1'b0; p_v <= 1'b0; p_d <= 1'b0; p_i <= 1'b1; p_z <= 1'b0; p_c <= 1'b0;
      nmi_q <= 1'b0; nmi_pend <= 1'b0; so_q <= 1'b1; int_nmi <= 1'b0;
    end else begin
      nmi_q <= NMI;
      so_q  <= SO;
      if (!stall) begin
        case (state)
          S_RESET, S_RS1, S_RS2: begin
            AB <= {8'h01, sp};
            sp <= sp - 8'd1;
            state <= (state == S_RESET) ? S_RS1 : (state == S_RS1) ? S_RS2 : S_RS3;
          end
          S_RS3: begin AB <= 16'hFFFC; state <= S_VECL; end
          S_VECL: begin tmp <= DI; AB <= {AB[15:1], 1'b1}; state <= S_VECH; end
          S_FETCH: begin ir <= DI; SYNC <= 1'b0; AB <= pc; state <= S_OP; end
          S_OP: begin
            case (ir)
              8'hA9, 8'h69, 8'h8A: a <= res;
              8'hA2, 8'hE8, 8'hCA, 8'hAA: x <= res;
              8'hA0, 8'hC8, 8'h88: y <= res;
              8'h18: p_c <= 1'b0;
              8'h38: p_c <= 1'b1;
              8'h58: p_i <= 1'b0;
              8'h78: p_i <= 1'b1;
              8'hB8: p_v <= 1'b0;
              8'hAD, 8'h8D, 8'h4C: begin
                tmp <= DI; pc <= pc + 16'd1; AB <= pc + 16'd1; state <= S_ABSH;
              end
              8'hD0, 8'hF0: if (br_take) begin
                pc <= br_target; AB <= pc + 16'd1; state <= S_BR;
              end
              8'h40: begin AB <= {8'h01, sp}; state <= S_RTI1; end
              default: ;
            endcase
            if (ir == 8'h69) begin p_c <= sum[8]; p_v <= ovf; end
          end
          S_ABSH: begin
            pc <= pc + 16'd1;
            AB <= {DI, tmp};
            state <= S_ABSX;
            if (ir == 8'h8D) begin RDWR_ <= 1'b0; DO <= a; end
          end
          S_ABSX: if (ir == 8'hAD) a <= res;
          S_RTI1, S_RTI2, S_RTI3: begin
            sp <= sp + 8'd1;
            AB <= {8'h01, sp + 8'd1};
            if (state == S_RTI2) {p_n, p_v, p_d, p_i, p_z, p_c} <= {DI[7:6], DI[3:0]};
            if (state == S_RTI3) tmp <= DI;
            state <= (state == S_RTI1) ? S_RTI2 : (state == S_RTI2) ? S_RTI3 : S_RTI4;
          end
          S_INT0: begin AB <= pc; state <= S_INT1; end
          S_INT1, S_INT2, S_INT3: begin
            AB <= {8'h01, sp};
            sp <= sp - 8'd1;
            RDWR_ <= 1'b0;
            DO <= (state == S_INT1) ? pc[15:8] : (state == S_INT2) ? pc[7:0] :
                  {p_n, p_v, 1'b1, 1'b0, p_d, p_i, p_z, p_c};
            state <= (state == S_INT1) ? S_INT2 : (state == S_INT2) ? S_INT3 : S_INT4;
          end
          S_INT4: begin
            RDWR_ <= 1'b1;
            AB <= int_nmi ? 16'hFFFA : 16'hFFFE;
            p_i <= 1'b1;
            state <= S_VECL;
          end
          default: ;
        endcase
        if (set_nz) begin p_n <= res[7]; p_z <= (res == 8'h00); end
        // instruction boundary: start either the next fetch or an interrupt sequence
        if (fin) begin
          RDWR_ <= 1'b1;
          AB <= fin_pc;
          if (take_int) begin
            pc <= fin_pc; SYNC <= 1'b0; int_nmi <= nmi_pend;
            nmi_pend <= 1'b0; state <= S_INT0;
          end else begin
            pc <= fin_pc + 16'd1; SYNC <= 1'b1; state <= S_FETCH;
          end
        end
      end
      if (NMI && !nmi_q) nmi_pend <= 1'b1;
      if (so_q && !SO) p_v <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ag_6502.sv
// tb/tb_ag_6502.sv - scoreboard bench for ag_6502
// Memory model on the bus; expected writes queued per scenario, popped by the bus monitor.
module tb_ag_6502;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        CLK_01, CLK_02, RDWR_, SYNC;
  logic [15:0] AB;
  logic [7:0]  DI, DO;
  logic        RDY = 1'b1, IRQ = 1'b0, NMI = 1'b0, SO = 1'b1;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_wr [$];
  logic [15:0] flog_a [$];
  int          flog_c [$];
  int          checks = 0, errors = 0, cyc = 0;

  always #5 CLK = ~CLK;
  always_comb DI = mem[AB];

  ag_6502 dut (.CLK(CLK), .RESET(RESET), .CLK_01(CLK_01), .CLK_02(CLK_02), .AB(AB),
               .RDWR_(RDWR_), .DI(DI), .DO(DO), .RDY(RDY), .IRQ(IRQ), .NMI(NMI),
               .SO(SO), .SYNC(SYNC));

  always @(negedge CLK) begin
    logic [23:0] w;
    cyc++;
    if (!RESET && SYNC === 1'b1) begin flog_a.push_back(AB); flog_c.push_back(cyc); end
    if (!RESET && RDWR_ === 1'b0) begin
      checks++;
      mem[AB] = DO;
      if (exp_wr.size() == 0) begin
        errors++; $display("FAIL wr_unexpected: got %h=%h, no write expected", AB, DO);
      end else begin
        w = exp_wr.pop_front();
        if ({AB, DO} !== w) begin
          errors++; $display("FAIL wr_data: got %h=%h, expected %h=%h", AB, DO, w[23:8], w[7:0]);
        end
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hE0;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'hF0;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hF8;
  endtask

  task automatic do_reset();
    RESET = 1'b1; RDY = 1'b1; NMI = 1'b0;
    @(negedge CLK); @(negedge CLK);
    #1; flog_a.delete(); flog_c.delete();
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic wait_fetch(input logic [15:0] a, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge CLK);
      if (SYNC === 1'b1 && AB === a) ok = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] seq [6] = '{16'h0100, 16'h01FF, 16'h01FE, 16'hFFFC, 16'hFFFD, 16'hE000};
    init_mem();
    @(negedge CLK);
    checks++;
    if ({AB, RDWR_, DO, SYNC} !== {16'h0000, 1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_outputs: got AB=%h RDWR_=%b DO=%h SYNC=%b, expected 0000 1 00 0", AB, RDWR_, DO, SYNC);
    end
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if (AB !== seq[i] || SYNC !== (i == 5) || RDWR_ !== 1'b1) begin
        errors++; $display("FAIL reset_seq[%0d]: got AB=%h SYNC=%b RDWR_=%b, expected AB=%h SYNC=%b RDWR_=1", i, AB, SYNC, RDWR_, seq[i], i == 5);
      end
    end
  endtask

  task automatic test_nop_stream();
    bit ok;
    init_mem();
    do_reset();
    wait_fetch(16'hE004, 30, ok);
    checks++;
    if (!ok || flog_a.size() != 5) begin
      errors++; $display("FAIL nop_timeout: reached=%b fetches=%0d, expected 1 and 5", ok, flog_a.size());
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (flog_a[k] !== 16'hE000 + 16'(k) || (k > 0 && flog_c[k] - flog_c[k-1] != 2)) begin
          errors++; $display("FAIL nop_fetch[%0d]: got %h, expected %h every 2 cycles", k, flog_a[k], 16'hE000 + 16'(k));
        end
      end
  endtask

  task automatic test_load_store();
    logic [7:0]  prog [9] = '{8'hA9, 8'h5A, 8'h8D, 8'h34, 8'h12, 8'hD0, 8'h02, 8'hEA, 8'hEA};
    logic [15:0] ea [4] = '{16'hE000, 16'hE002, 16'hE005, 16'hE009};
    int          ed [4] = '{0, 2, 4, 3};
    bit ok;
    init_mem();
    foreach (prog[i]) mem[16'hE000 + 16'(i)] = prog[i];
    exp_wr.push_back({16'h1234, 8'h5A});
    do_reset();
    wait_fetch(16'hE009, 40, ok);
    checks++;
    if (!ok || flog_a.size() != 4) begin
      errors++; $display("FAIL ldst_timeout: reached=%b fetches=%0d, expected 1 and 4", ok, flog_a.size());
    end else
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (flog_a[k] !== ea[k] || (k > 0 && flog_c[k] - flog_c[k-1] != ed[k])) begin
          errors++; $display("FAIL ldst_fetch[%0d]: got %h, expected %h after %0d cycles", k, flog_a[k], ea[k], ed[k]);
        end
      end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++; $display("FAIL ldst_pending: got %0d writes missing, expected 0", exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic test_branch();
    logic [7:0]  prog [13] = '{8'hA2, 8'h01, 8'hCA, 8'hD0, 8'hFE, 8'hF0, 8'h02, 8'hEA, 8'hEA,
                               8'h8A, 8'h8D, 8'h00, 8'h02};
    logic [15:0] ea [7] = '{16'hE000, 16'hE002, 16'hE003, 16'hE005, 16'hE009, 16'hE00A, 16'hE00D};
    int          ed [7] = '{0, 2, 2, 2, 3, 2, 4};
    bit ok;
    init_mem();
    foreach (prog[i]) mem[16'hE000 + 16'(i)] = prog[i];
    exp_wr.push_back({16'h0200, 8'h00});
    do_reset();
    wait_fetch(16'hE00D, 50, ok);
    checks++;
    if (!ok || flog_a.size() != 7) begin
      errors++; $display("FAIL branch_timeout: reached=%b fetches=%0d, expected 1 and 7", ok, flog_a.size());
    end else
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (flog_a[k] !== ea[k] || (k > 0 && flog_c[k] - flog_c[k-1] != ed[k])) begin
          errors++; $display("FAIL branch_fetch[%0d]: got %h, expected %h after %0d cycles", k, flog_a[k], ea[k], ed[k]);
        end
      end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++; $display("FAIL branch_pending: got %0d writes missing, expected 0", exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic test_adc();
    logic [7:0] prog [24] = '{8'hA9, 8'hFF, 8'h69, 8'h01, 8'h69, 8'h00, 8'h8D, 8'h00, 8'h03,
                              8'hA9, 8'h7F, 8'h69, 8'h01, 8'h8D, 8'h01, 8'h03,
                              8'hA2, 8'hFF, 8'hE8, 8'h8A, 8'h8D, 8'h02, 8'h03, 8'hEA};
    bit ok;
    init_mem();
    foreach (prog[i]) mem[16'hE000 + 16'(i)] = prog[i];
    exp_wr.push_back({16'h0300, 8'h01});
    exp_wr.push_back({16'h0301, 8'h80});
    exp_wr.push_back({16'h0302, 8'h00});
    do_reset();
    wait_fetch(16'hE017, 80, ok);
    checks++;
    if (!ok || exp_wr.size() != 0) begin
      errors++; $display("FAIL adc_done: reached=%b missing=%0d, expected 1 and 0", ok, exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic test_nmi();
    bit ok;
    int n;
    init_mem();
    mem[16'hE000] = 8'h58;
    do_reset();
    wait_fetch(16'hE00F, 40, ok);
    NMI = 1'b1;
    exp_wr.push_back({16'h01FD, 8'hE0});
    exp_wr.push_back({16'h01FC, 8'h10});
    exp_wr.push_back({16'h01FB, 8'h20});
    @(negedge CLK); NMI = 1'b0;
    wait_fetch(16'hF000, 20, ok);
    n = flog_a.size();
    checks++;
    if (!ok || n < 2 || flog_a[n-2] !== 16'hE00F || flog_c[n-1] - flog_c[n-2] != 9) begin
      errors++; $display("FAIL nmi_vector: reached=%b fetches=%0d, expected fetch F000 9 cycles after E00F", ok, n);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++; $display("FAIL nmi_pending: got %0d writes missing, expected 0", exp_wr.size());
      exp_wr.delete();
    end
    wait_fetch(16'hF00F, 40, ok);
    NMI = 1'b1;
    exp_wr.push_back({16'h01FA, 8'hF0});
    exp_wr.push_back({16'h01F9, 8'h10});
    exp_wr.push_back({16'h01F8, 8'h24});
    @(negedge CLK); NMI = 1'b0;
    wait_fetch(16'hF000, 20, ok);
    checks++;
    if (!ok || exp_wr.size() != 0) begin
      errors++; $display("FAIL nmi_second: reached=%b missing=%0d, expected 1 and 0", ok, exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic test_irq_rti();
    bit ok;
    int n;
    init_mem();
    mem[16'hE004] = 8'h58;
    mem[16'hF800] = 8'h40;
    IRQ = 1'b1;
    exp_wr.push_back({16'h01FD, 8'hE0});
    exp_wr.push_back({16'h01FC, 8'h06});
    exp_wr.push_back({16'h01FB, 8'h20});
    do_reset();
    wait_fetch(16'hF800, 60, ok);
    IRQ = 1'b0;
    n = flog_a.size();
    checks++;
    if (!ok || n < 2 || flog_a[n-2] !== 16'hE005) begin
      errors++; $display("FAIL irq_entry: reached=%b fetches=%0d, expected F800 right after E005", ok, n);
    end
    wait_fetch(16'hE006, 20, ok);
    n = flog_a.size();
    checks++;
    if (!ok || n < 2 || flog_c[n-1] - flog_c[n-2] != 6) begin
      errors++; $display("FAIL rti_return: reached=%b, expected E006 6 cycles after F800", ok);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++; $display("FAIL irq_pending: got %0d writes missing, expected 0", exp_wr.size());
      exp_wr.delete();
    end
  endtask

  task automatic test_rdy();
    bit ok;
    init_mem();
    do_reset();
    wait_fetch(16'hE002, 20, ok);
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (AB !== 16'hE002 || SYNC !== 1'b1) begin
        errors++; $display("FAIL rdy_hold[%0d]: got AB=%h SYNC=%b, expected E002 1", i, AB, SYNC);
      end
    end
    RDY = 1'b1;
    @(negedge CLK);
    checks++;
    if (AB !== 16'hE003 || SYNC !== 1'b0) begin
      errors++; $display("FAIL rdy_resume: got AB=%h SYNC=%b, expected E003 0", AB, SYNC);
    end
    @(negedge CLK);
    checks++;
    if (AB !== 16'hE003 || SYNC !== 1'b1) begin
      errors++; $display("FAIL rdy_next: got AB=%h SYNC=%b, expected E003 1", AB, SYNC);
    end
  endtask

  task automatic test_midop_reset();
    logic [7:0]  prog [5] = '{8'hA9, 8'h5A, 8'h8D, 8'h34, 8'h12};
    logic [15:0] seq [6] = '{16'h0100, 16'h01FF, 16'h01FE, 16'hFFFC, 16'hFFFD, 16'hE000};
    bit hit = 1'b0;
    init_mem();
    foreach (prog[i]) mem[16'hE000 + 16'(i)] = prog[i];
    exp_wr.push_back({16'h1234, 8'h5A});
    do_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge CLK);
      if (RDWR_ === 1'b0) hit = 1'b1;
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (!hit || RDWR_ !== 1'b1 || AB !== 16'h0000 || DO !== 8'h00) begin
      errors++; $display("FAIL midop_abort: write_seen=%b RDWR_=%b AB=%h DO=%h, expected 1 1 0000 00", hit, RDWR_, AB, DO);
    end
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if (AB !== seq[i] || SYNC !== (i == 5) || RDWR_ !== 1'b1) begin
        errors++; $display("FAIL midop_seq[%0d]: got AB=%h SYNC=%b, expected AB=%h SYNC=%b", i, AB, SYNC, seq[i], i == 5);
      end
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++; $display("FAIL midop_pending: got %0d writes missing, expected 0", exp_wr.size());
      exp_wr.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nop_stream();
    test_load_store();
    test_branch();
    test_adc();
    test_nmi();
    test_irq_rti();
    test_rdy();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
